// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the multi-cycle CPU.
// Accepts one load/store per handshake, waits WAIT_CYC cycles, then answers with a single pulse.
//
// state  | meaning
// S_IDLE | ready, waiting for req
// S_WAIT | wait-state countdown after accept
// S_RESP | one-cycle rvalid / wdone / err pulse
module dmem_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wdone,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ill_q, ill_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                rvalid_q, rvalid_d;
  logic                wdone_q, wdone_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                req_ill;
  logic                enter_resp;
  logic                use_in;
  logic                acc_we;
  logic                acc_ill;
  logic [ADDR_W-1:0]   acc_idx;
  logic [DATA_W-1:0]   acc_wdata;
  logic                mem_wr;

  assign req_ill = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    ill_d      = ill_q;
    enter_resp = 1'b0;
    use_in     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = wdata;
          ill_d   = req_ill;
          if (WAIT_CYC == 0) begin
            // zero wait states: the access happens on the accept edge itself
            state_d    = S_RESP;
            enter_resp = 1'b1;
            use_in     = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    acc_we    = use_in ? we                : we_q;
    acc_ill   = use_in ? req_ill           : ill_q;
    acc_idx   = use_in ? addr[ADDR_W+1:2]  : idx_q;
    acc_wdata = use_in ? wdata             : wdata_q;

    mem_wr   = 1'b0;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (enter_resp) begin
      if (acc_ill) begin
        err_d = 1'b1;
      end else if (acc_we) begin
        wdone_d = 1'b1;
        mem_wr  = 1'b1;
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = mem[acc_idx];
      end
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ill_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ill_q    <= ill_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Array is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && mem_wr) mem[acc_idx] <= acc_wdata;
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign rvalid = rvalid_q;
  assign wdone  = wdone_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic             clk;
  logic             rst;
  logic [1:0]       req_v, we_v;
  logic [1:0][31:0] addr_v, wdata_v;
  logic [1:0]       ready_v, rvalid_v, wdone_v, err_v, busy_v;
  logic [1:0][31:0] rdata_v;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int last_acc [2];

  logic [31:0] model_mem [2][256];
  bit          written   [2][256];
  logic [31:0] rdata_exp [2];

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(W0)) u_w2 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .ready(ready_v[0]), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]), .wdone(wdone_v[0]),
    .err(err_v[0]), .busy(busy_v[0])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(W1)) u_w0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .ready(ready_v[1]), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]), .wdone(wdone_v[1]),
    .err(err_v[1]), .busy(busy_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic int wait_of(input int s);
    return (s == 0) ? W0 : W1;
  endfunction

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_ready"},  32'(ready_v[s]),  32'd1);
    chk({tag, "_busy"},   32'(busy_v[s]),   32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid_v[s]), 32'd0);
    chk({tag, "_wdone"},  32'(wdone_v[s]),  32'd0);
    chk({tag, "_err"},    32'(err_v[s]),    32'd0);
    chk({tag, "_rdata"},  rdata_v[s],       rdata_exp[s]);
  endtask

  // Called at a negedge; returns at the negedge where the responder is idle again.
  task automatic access(input int s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    int  budget;
    int  lat;
    bit  ill;
    req_v[s]   = 1'b1;
    we_v[s]    = w;
    addr_v[s]  = a;
    wdata_v[s] = d;
    budget = 0;
    while (!ready_v[s] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!ready_v[s]) begin
      chk("accept_timeout", 32'(ready_v[s]), 32'd1);
      req_v[s] = 1'b0;
      return;
    end
    last_acc[s] = cyc;
    lat = wait_of(s) + 1;
    ill = (a % 4 != 0) || (a >= 32'd1024);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) req_v[s] = 1'b0;
      chk("inflight_ready", 32'(ready_v[s]), 32'd0);
      chk("inflight_busy",  32'(busy_v[s]),  32'd1);
      if (n < lat) begin
        chk("early_pulse", {29'd0, rvalid_v[s], wdone_v[s], err_v[s]}, 32'd0);
      end else begin
        chk("rvalid", 32'(rvalid_v[s]), 32'(!ill && !w));
        chk("wdone",  32'(wdone_v[s]),  32'(!ill && w));
        chk("err",    32'(err_v[s]),    32'(ill));
      end
    end
    if (!ill) begin
      if (w) begin
        model_mem[s][a / 4] = d;
        written[s][a / 4]   = 1'b1;
      end else begin
        rdata_exp[s] = model_mem[s][a / 4];
      end
    end
    @(negedge clk);
    chk_idle(s, "post");
  endtask

  initial begin
    int acc_c [4];
    bit w;
    logic [31:0] a;
    int  r;
    rst     = 1'b0;
    req_v   = 2'b11;
    we_v    = 2'b11;
    addr_v  = '{32'h40, 32'h40};
    wdata_v = '{32'h0BAD_0BAD, 32'h0BAD_0BAD};
    rdata_exp = '{32'd0, 32'd0};
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) written[s][i] = 1'b0;

    // reset held with req asserted
    repeat (3) begin
      @(negedge clk);
      chk_idle(0, "rst0");
      chk_idle(1, "rst1");
    end
    rst   = 1'b1;
    req_v = 2'b00;
    repeat (4) begin
      @(negedge clk);
      chk_idle(0, "rel0");
      chk_idle(1, "rel1");
    end

    // store then load, 2 wait states
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("load_10", rdata_v[0], 32'hDEAD_BEEF);

    // illegal accesses
    access(0, 1'b1, 32'h13, 32'h1111_1111, 1'b0);
    access(0, 1'b0, 32'h400, 32'h0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("load_10_again", rdata_v[0], 32'hDEAD_BEEF);

    // back-to-back stores with req held high
    for (int k = 0; k < 4; k++) begin
      access(0, 1'b1, 32'h80 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 1'b1);
      acc_c[k] = last_acc[0];
    end
    req_v[0] = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(acc_c[k] - acc_c[k-1]), 32'(W0 + 2));
    for (int k = 0; k < 4; k++) access(0, 1'b0, 32'h80 + 32'(k * 4), 32'h0, 1'b0);
    chk("b2b_last", rdata_v[0], 32'hA5A5_0003);

    // reset during the wait of a store
    access(0, 1'b1, 32'h20, 32'h0000_AAAA, 1'b0);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h1234_5678;
    @(negedge clk);
    chk("abort_in_wait", 32'(ready_v[0]), 32'd0);
    req_v[0] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rdata_exp = '{32'd0, 32'd0};
    chk_idle(0, "abort_rst");
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_wdone", 32'(wdone_v[0]), 32'd0);
    end
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("abort_prior", rdata_v[0], 32'h0000_AAAA);

    // zero wait states, top word, req held through the response cycle
    access(1, 1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0);
    access(1, 1'b0, 32'h3FC, 32'h0, 1'b1);
    acc_c[0] = last_acc[1];
    access(1, 1'b0, 32'h3FC, 32'h0, 1'b1);
    acc_c[1] = last_acc[1];
    req_v[1] = 1'b0;
    chk("w0_spacing", 32'(acc_c[1] - acc_c[0]), 32'(W1 + 2));
    chk("w0_top", rdata_v[1], 32'hCAFE_F00D);
    access(1, 1'b1, 32'h3FE, 32'h0, 1'b0);

    // random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 50; i++) begin
        r = $urandom_range(0, 9);
        w = 1'($urandom_range(0, 1));
        if (r == 0)      a = ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
        else if (r == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else begin
          a = $urandom_range(0, 255) * 4;
          if (!w && !written[s][a / 4]) w = 1'b1;
        end
        access(s, w, a, $urandom, (i != 49) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      req_v[s] = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
